// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid entry,
// hold (busywait) and flush. Empty slots present the bubble control word.
module pipe_stage_reg #(
    parameter int unsigned          DATA_W      = 160,
    parameter int unsigned          CTRL_W      = 24,
    parameter logic [CTRL_W-1:0]    CTRL_BUBBLE = '0,
    parameter int unsigned          SKID        = 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              accept;
    logic              emit;

    // With a skid entry, in_ready depends on registered state only.
    always_comb begin
        if (SKID != 0)
            in_ready = !skid_valid && !hold && !reset;
        else
            in_ready = (!main_valid || out_ready) && !hold && !reset;
    end

    assign accept    = in_valid && in_ready;
    assign emit      = main_valid && out_ready && !hold;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    always_ff @(posedge CLK) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= CTRL_BUBBLE;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= CTRL_BUBBLE;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_ctrl  <= CTRL_BUBBLE;
            skid_valid <= 1'b0;
        end else if (!hold) begin
            if (!main_valid || emit) begin
                // A held skid entry always drains before any newer input.
                if (skid_valid) begin
                    main_valid <= 1'b1;
                    main_data  <= skid_data;
                    main_ctrl  <= skid_ctrl;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    main_valid <= 1'b1;
                    main_data  <= in_data;
                    main_ctrl  <= in_ctrl;
                end else begin
                    main_valid <= 1'b0;
                    main_ctrl  <= CTRL_BUBBLE;
                end
            end else if (accept && (SKID != 0)) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
                skid_ctrl  <= in_ctrl;
            end
        end
    end

endmodule
